// File: rtl/lbm_pkg.sv
// lbm_pkg: shared constants and types for the D2Q9 stream selector.
//   DIST_W      : width of one lattice distribution
//   Q           : distributions per node (D2Q9)
//   NODE_W      : width of one packed node word
//   sel_state_t : selector control state
package lbm_pkg;
  localparam int DIST_W = 32;
  localparam int Q      = 9;
  localparam int NODE_W = Q * DIST_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MANUAL = 2'd1,
    SCAN   = 2'd2
  } sel_state_t;
endpackage

// File: rtl/lbm_out_reg.sv
// lbm_out_reg: single-stage valid/ready output register carrying a data
// word plus a tag.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture d/tag this cycle (only when can_load is high)
//   d, tag     : incoming word and its tag
//   q_ready    : downstream accept
//   q, q_tag   : registered word and tag (change only on load)
//   q_valid    : registered word valid
//   can_load   : register is empty or being drained this cycle
module lbm_out_reg #(
  parameter int DATA_WIDTH = lbm_pkg::NODE_W,
  parameter int TAG_W      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         load,
  input  logic signed [DATA_WIDTH-1:0] d,
  input  logic        [TAG_W-1:0]      tag,
  input  logic                         q_ready,
  output logic signed [DATA_WIDTH-1:0] q,
  output logic        [TAG_W-1:0]      q_tag,
  output logic                         q_valid,
  output logic                         can_load
);

  assign can_load = !q_valid | q_ready;

  // stage p0 -> p1: word and tag held until the next load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q       <= '0;
      q_tag   <= '0;
      q_valid <= 1'b0;
    end else if (load) begin
      q       <= d;
      q_tag   <= tag;
      q_valid <= 1'b1;
    end else if (q_ready) begin
      q_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lbm_stream_sel.sv
// lbm_stream_sel: pipelined N-way selector for D2Q9 node words with
// per-channel valid/ready, a registered output and an index-order scan.
//   clk, reset  : clock, asynchronous active-high reset
//   din         : packed channel words, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   din_valid   : per-channel valid
//   din_ready   : per-channel ready, one-hot or zero, combinational
//   mode        : 0 manual, 1 scan (sampled on start)
//   start/abort : begin operation from IDLE / return to IDLE
//   sel_in      : channel select in manual mode
//   dout, dout_valid, dout_ready, sel_out : registered output word, valid,
//                 downstream accept and source channel index
//   scan_done   : one-cycle pulse after the last scan transfer
module lbm_stream_sel
  import lbm_pkg::*;
#(
  parameter int DATA_WIDTH = NODE_W,
  parameter int N_IN       = 11,
  parameter int SEL_W      = $clog2(N_IN)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_IN*DATA_WIDTH-1:0]   din,
  input  logic [N_IN-1:0]              din_valid,
  output logic [N_IN-1:0]              din_ready,
  input  logic                         mode,
  input  logic                         start,
  input  logic                         abort,
  input  logic [SEL_W-1:0]             sel_in,
  output logic signed [DATA_WIDTH-1:0] dout,
  output logic                         dout_valid,
  input  logic                         dout_ready,
  output logic [SEL_W-1:0]             sel_out,
  output logic                         scan_done
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(N_IN - 1);

  sel_state_t                   state, state_nx;
  logic [SEL_W-1:0]             idx, idx_nx, act;
  logic                         done_nx;
  logic                         can_load, go, act_vld, xfer_p0;
  logic signed [DATA_WIDTH-1:0] word_p0;

  // Active channel; out-of-range manual selects fall back to channel 0.
  always_comb begin
    act = '0;
    if (state == MANUAL) begin
      act = (int'(sel_in) >= N_IN) ? '0 : sel_in;
    end else if (state == SCAN) begin
      act = idx;
    end
  end

  assign go = (state != IDLE) & !abort & can_load;

  // stage p0: input mux and one-hot ready decode
  always_comb begin
    word_p0   = '0;
    act_vld   = 1'b0;
    din_ready = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (act == SEL_W'(i)) begin
        word_p0      = din[i*DATA_WIDTH +: DATA_WIDTH];
        act_vld      = din_valid[i];
        din_ready[i] = go;
      end
    end
  end

  assign xfer_p0 = act_vld & go;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    done_nx  = 1'b0;
    if (abort) begin
      state_nx = IDLE;
      idx_nx   = '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = mode ? SCAN : MANUAL;
            idx_nx   = '0;
          end
        end
        MANUAL: ;
        SCAN: begin
          if (xfer_p0) begin
            if (idx == LAST) begin
              state_nx = IDLE;
              idx_nx   = '0;
              done_nx  = 1'b1;
            end else begin
              idx_nx = idx + 1'b1;
            end
          end
        end
        default: begin
          state_nx = IDLE;
          idx_nx   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      scan_done <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      scan_done <= done_nx;
    end
  end

  // stage p0 -> p1: registered output word and source index
  lbm_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_W      (SEL_W)
  ) u_out (
    .clk      (clk),
    .reset    (reset),
    .load     (xfer_p0),
    .d        (word_p0),
    .tag      (act),
    .q_ready  (dout_ready),
    .q        (dout),
    .q_tag    (sel_out),
    .q_valid  (dout_valid),
    .can_load (can_load)
  );

endmodule
